// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one registered data-memory port.
// Every access takes a grant cycle followed by a completion cycle.
module mem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDRSIZE-1:0] m0_addr,
    input  logic [WIDTH-1:0]    m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDRSIZE-1:0] m1_addr,
    input  logic [WIDTH-1:0]    m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [WIDTH-1:0]    rdata,
    output logic [ADDRSIZE-1:0] MEM_ADDR,
    output logic [WIDTH-1:0]    MEM_OUT,
    output logic                MEM_CTRL,
    input  logic [WIDTH-1:0]    MEM_IN,
    output logic                busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  win_q, win_d;
    logic                  rd_q, rd_d;
    logic [ADDRSIZE-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  ctrl_q, ctrl_d;
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  rv0_q, rv0_d;
    logic                  rv1_q, rv1_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  any_req_s;
    logic                  sel_s;

    // On a tie the master that was not granted last wins; rr_q holds the last winner.
    assign any_req_s = m0_req | m1_req;
    assign sel_s     = (m0_req & m1_req) ? ~rr_q : m1_req;

    // Next-state and registered-output decode for the IDLE/BUSY access sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        rdata_d = rdata_q;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    win_d   = sel_s;
                    rr_d    = sel_s;
                    addr_d  = sel_s ? m1_addr  : m0_addr;
                    wdata_d = sel_s ? m1_wdata : m0_wdata;
                    ctrl_d  = sel_s ? m1_we    : m0_we;
                    rd_d    = sel_s ? ~m1_we   : ~m0_we;
                    gnt0_d  = ~sel_s;
                    gnt1_d  = sel_s;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                state_d = IDLE;
                if (rd_q) begin
                    rdata_d = MEM_IN;
                    rv0_d   = ~win_q;
                    rv1_d   = win_q;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves master 1 as last winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
            win_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= {ADDRSIZE{1'b0}};
            wdata_q <= {WIDTH{1'b0}};
            ctrl_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign rdata     = rdata_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_OUT   = wdata_q;
    assign MEM_CTRL  = ctrl_q;
    assign busy      = busy_q;

endmodule
